// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared types and constants for the multicycle MIPS control unit (MC_CTRL_ADDI_EN adds addi)
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
`ifdef MC_CTRL_ADDI_EN
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11,
`endif
    S_JUMP    = 4'd9
  } state_t;

  typedef enum logic [1:0] {
    ALU_OP_ADD   = 2'b00,
    ALU_OP_SUB   = 2'b01,
    ALU_OP_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  function automatic logic op_supported(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: op_supported = 1'b1;
`ifdef MC_CTRL_ADDI_EN
      OP_ADDI:                              op_supported = 1'b1;
`endif
      default:                              op_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_controller_if.sv
// rtl/mc_controller_if.sv - control bus between the multicycle controller and the datapath
interface mc_controller_if (
  input logic clk,
  input logic rst_n
);
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       iord;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_ctrl_sig;
  logic [1:0] pc_src;
  logic       pc_en;
  logic       illegal;

  modport slave (
    input  clk, rst_n, op, funct, zero, mem_ready,
    output iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, alu_ctrl_sig, pc_src, pc_en, illegal
  );

  modport master (
    input  clk, rst_n, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, alu_ctrl_sig, pc_src, pc_en, illegal,
    output op, funct, zero, mem_ready
  );
endinterface

// File: rtl/mc_alu_dec.sv
// rtl/mc_alu_dec.sv - ALU control decode from alu_op and funct
module mc_alu_dec
  import mc_ctrl_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_ctrl_sig,
  output logic       bad_funct
);

  always_comb begin
    alu_ctrl_sig = ALU_ADD;
    bad_funct    = 1'b0;
    case (alu_op)
      ALU_OP_SUB: alu_ctrl_sig = ALU_SUB;
      ALU_OP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_ctrl_sig = ALU_ADD;
          FN_SUB:  alu_ctrl_sig = ALU_SUB;
          FN_AND:  alu_ctrl_sig = ALU_AND;
          FN_OR:   alu_ctrl_sig = ALU_OR;
          FN_SLT:  alu_ctrl_sig = ALU_SLT;
          default: bad_funct    = 1'b1;
        endcase
      end
      default: alu_ctrl_sig = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle MIPS control FSM; MC_CTRL_ADDI_EN enables addi decode
module mc_controller
  import mc_ctrl_pkg::*;
(
  mc_controller_if.slave ctrl_bus
);

  state_t  state;
  alu_op_t alu_op;
  logic    pc_write;
  logic    branch;
  logic    bad_funct;

  always_ff @(posedge ctrl_bus.clk) begin
    if (!ctrl_bus.rst_n) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:   if (ctrl_bus.mem_ready) state <= S_DECODE;
        S_DECODE: begin
          case (ctrl_bus.op)
            OP_LW, OP_SW: state <= S_MEMADR;
            OP_RTYPE:     state <= S_EXECUTE;
            OP_BEQ:       state <= S_BRANCH;
`ifdef MC_CTRL_ADDI_EN
            OP_ADDI:      state <= S_ADDIEX;
`endif
            OP_J:         state <= S_JUMP;
            default:      state <= S_FETCH;
          endcase
        end
        S_MEMADR:  state <= (ctrl_bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:   if (ctrl_bus.mem_ready) state <= S_MEMWB;
        S_MEMWR:   if (ctrl_bus.mem_ready) state <= S_FETCH;
        S_EXECUTE: state <= bad_funct ? S_FETCH : S_ALUWB;
`ifdef MC_CTRL_ADDI_EN
        S_ADDIEX:  state <= S_ADDIWB;
`endif
        default:   state <= S_FETCH;
      endcase
    end
  end

  // alu_op is kept apart from the main decode so bad_funct feeds back without a comb loop
  always_comb begin
    alu_op = ALU_OP_ADD;
    if (ctrl_bus.rst_n) begin
      case (state)
        S_EXECUTE: alu_op = ALU_OP_FUNCT;
        S_BRANCH:  alu_op = ALU_OP_SUB;
        default:   alu_op = ALU_OP_ADD;
      endcase
    end
  end

  mc_alu_dec u_alu_dec (
    .alu_op       (alu_op),
    .funct        (ctrl_bus.funct),
    .alu_ctrl_sig (ctrl_bus.alu_ctrl_sig),
    .bad_funct    (bad_funct)
  );

  always_comb begin
    ctrl_bus.iord       = 1'b0;
    ctrl_bus.mem_write  = 1'b0;
    ctrl_bus.ir_write   = 1'b0;
    ctrl_bus.reg_dst    = 1'b0;
    ctrl_bus.mem_to_reg = 1'b0;
    ctrl_bus.reg_write  = 1'b0;
    ctrl_bus.alu_src_a  = 1'b0;
    ctrl_bus.alu_src_b  = 2'b00;
    ctrl_bus.pc_src     = 2'b00;
    ctrl_bus.illegal    = 1'b0;
    pc_write            = 1'b0;
    branch              = 1'b0;
    case (state)
      S_FETCH: begin
        ctrl_bus.alu_src_b = 2'b01;
        ctrl_bus.ir_write  = ctrl_bus.mem_ready;
        pc_write           = ctrl_bus.mem_ready;
      end
      S_DECODE: begin
        ctrl_bus.alu_src_b = 2'b11;
        ctrl_bus.illegal   = !op_supported(ctrl_bus.op);
      end
      S_MEMADR: begin
        ctrl_bus.alu_src_a = 1'b1;
        ctrl_bus.alu_src_b = 2'b10;
      end
      S_MEMRD: ctrl_bus.iord = 1'b1;
      S_MEMWB: begin
        ctrl_bus.mem_to_reg = 1'b1;
        ctrl_bus.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        ctrl_bus.iord      = 1'b1;
        ctrl_bus.mem_write = 1'b1;
      end
      S_EXECUTE: begin
        ctrl_bus.alu_src_a = 1'b1;
        ctrl_bus.illegal   = bad_funct;
      end
      S_ALUWB: begin
        ctrl_bus.reg_dst   = 1'b1;
        ctrl_bus.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl_bus.alu_src_a = 1'b1;
        ctrl_bus.pc_src    = 2'b01;
        branch             = 1'b1;
      end
`ifdef MC_CTRL_ADDI_EN
      S_ADDIEX: begin
        ctrl_bus.alu_src_a = 1'b1;
        ctrl_bus.alu_src_b = 2'b10;
      end
      S_ADDIWB: ctrl_bus.reg_write = 1'b1;
`endif
      S_JUMP: begin
        ctrl_bus.pc_src = 2'b10;
        pc_write        = 1'b1;
      end
      default: ctrl_bus.alu_src_b = 2'b01;
    endcase

    // Held in reset: FETCH selects with every strobe quiet, whatever state is still registered
    if (!ctrl_bus.rst_n) begin
      ctrl_bus.iord       = 1'b0;
      ctrl_bus.mem_write  = 1'b0;
      ctrl_bus.ir_write   = 1'b0;
      ctrl_bus.reg_dst    = 1'b0;
      ctrl_bus.mem_to_reg = 1'b0;
      ctrl_bus.reg_write  = 1'b0;
      ctrl_bus.alu_src_a  = 1'b0;
      ctrl_bus.alu_src_b  = 2'b01;
      ctrl_bus.pc_src     = 2'b00;
      ctrl_bus.illegal    = 1'b0;
      pc_write            = 1'b0;
      branch              = 1'b0;
    end
  end

  assign ctrl_bus.pc_en = pc_write | (branch & ctrl_bus.zero);

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - scoreboard bench for mc_controller (honours MC_CTRL_ADDI_EN)
module tb_mc_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  mc_controller_if bus (.clk(clk), .rst_n(rst_n));

  mc_controller dut (.ctrl_bus(bus));

  // {iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_ctrl, pc_src, pc_en, illegal}
  localparam logic [15:0] E_RST    = {7'b0000000, 2'b01, 3'b010, 2'b00, 1'b0, 1'b0};
  localparam logic [15:0] E_F0     = {7'b0000000, 2'b01, 3'b010, 2'b00, 1'b0, 1'b0};
  localparam logic [15:0] E_F1     = {7'b0010000, 2'b01, 3'b010, 2'b00, 1'b1, 1'b0};
  localparam logic [15:0] E_DEC    = {7'b0000000, 2'b11, 3'b010, 2'b00, 1'b0, 1'b0};
  localparam logic [15:0] E_DECILL = {7'b0000000, 2'b11, 3'b010, 2'b00, 1'b0, 1'b1};
  localparam logic [15:0] E_MADR   = {7'b0000001, 2'b10, 3'b010, 2'b00, 1'b0, 1'b0};
  localparam logic [15:0] E_MRD    = {7'b1000000, 2'b00, 3'b010, 2'b00, 1'b0, 1'b0};
  localparam logic [15:0] E_MWB    = {7'b0000110, 2'b00, 3'b010, 2'b00, 1'b0, 1'b0};
  localparam logic [15:0] E_MWR    = {7'b1100000, 2'b00, 3'b010, 2'b00, 1'b0, 1'b0};
  localparam logic [15:0] E_EXSLT  = {7'b0000001, 2'b00, 3'b111, 2'b00, 1'b0, 1'b0};
  localparam logic [15:0] E_EXAND  = {7'b0000001, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0};
  localparam logic [15:0] E_EXOR   = {7'b0000001, 2'b00, 3'b001, 2'b00, 1'b0, 1'b0};
  localparam logic [15:0] E_EXSUB  = {7'b0000001, 2'b00, 3'b110, 2'b00, 1'b0, 1'b0};
  localparam logic [15:0] E_EXBAD  = {7'b0000001, 2'b00, 3'b010, 2'b00, 1'b0, 1'b1};
  localparam logic [15:0] E_AWB    = {7'b0001010, 2'b00, 3'b010, 2'b00, 1'b0, 1'b0};
  localparam logic [15:0] E_BR1    = {7'b0000001, 2'b00, 3'b110, 2'b01, 1'b1, 1'b0};
  localparam logic [15:0] E_BR0    = {7'b0000001, 2'b00, 3'b110, 2'b01, 1'b0, 1'b0};
  localparam logic [15:0] E_JMP    = {7'b0000000, 2'b00, 3'b010, 2'b10, 1'b1, 1'b0};
`ifdef MC_CTRL_ADDI_EN
  localparam logic [15:0] E_AIEX   = {7'b0000001, 2'b10, 3'b010, 2'b00, 1'b0, 1'b0};
  localparam logic [15:0] E_AIWB   = {7'b0000010, 2'b00, 3'b010, 2'b00, 1'b0, 1'b0};
`endif

  localparam logic [5:0] RT = 6'b000000;
  localparam logic [5:0] LW = 6'b100011;
  localparam logic [5:0] SW = 6'b101011;
  localparam logic [5:0] BQ = 6'b000100;
  localparam logic [5:0] AI = 6'b001000;
  localparam logic [5:0] JP = 6'b000010;
  localparam logic [5:0] XX = 6'b111111;

  typedef struct {
    logic [15:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic step(input logic rn, input logic [5:0] o, input logic [5:0] f,
                      input logic z, input logic mr, input logic [15:0] e, input string nm);
    exp_t item;
    rst_n         = rn;
    bus.op        = o;
    bus.funct     = f;
    bus.zero      = z;
    bus.mem_ready = mr;
    item.exp      = e;
    item.name     = nm;
    sb.push_back(item);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t        item;
    logic [15:0] got;
    if (sb.size() > 0) begin
      item = sb.pop_front();
      got = {bus.iord, bus.mem_write, bus.ir_write, bus.reg_dst, bus.mem_to_reg,
             bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_ctrl_sig,
             bus.pc_src, bus.pc_en, bus.illegal};
      n_cmp++;
      if (got !== item.exp) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h", item.name, got, item.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.op = 6'd0;
    bus.funct = 6'd0;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    step(0, RT, 6'd0, 0, 0, E_RST, "reset_mr0");
    step(0, RT, 6'd0, 1, 1, E_RST, "reset_mr1");
    step(1, LW, 6'd0, 0, 0, E_F0,  "fetch_stall");
    step(1, LW, 6'd0, 0, 1, E_F1,  "fetch_go");
    // lw, one MEMRD stall, mem_ready low in DECODE is ignored
    step(1, LW, 6'd0, 0, 0, E_DEC,  "lw_decode");
    step(1, LW, 6'd0, 0, 1, E_MADR, "lw_memadr");
    step(1, LW, 6'd0, 0, 0, E_MRD,  "lw_memrd_stall");
    step(1, LW, 6'd0, 0, 1, E_MRD,  "lw_memrd");
    step(1, LW, 6'd0, 0, 1, E_MWB,  "lw_memwb");
    // lw with no stall: 5 cycles
    step(1, LW, 6'd0, 0, 1, E_F1,   "lw2_fetch");
    step(1, LW, 6'd0, 0, 1, E_DEC,  "lw2_decode");
    step(1, LW, 6'd0, 0, 1, E_MADR, "lw2_memadr");
    step(1, LW, 6'd0, 0, 1, E_MRD,  "lw2_memrd");
    step(1, LW, 6'd0, 0, 1, E_MWB,  "lw2_memwb");
    // sw with two MEMWR stall cycles
    step(1, SW, 6'd0, 0, 1, E_F1,   "sw_fetch");
    step(1, SW, 6'd0, 0, 1, E_DEC,  "sw_decode");
    step(1, SW, 6'd0, 0, 1, E_MADR, "sw_memadr");
    step(1, SW, 6'd0, 0, 0, E_MWR,  "sw_memwr_0");
    step(1, SW, 6'd0, 0, 0, E_MWR,  "sw_memwr_1");
    step(1, SW, 6'd0, 0, 1, E_MWR,  "sw_memwr_2");
    // beq taken and not taken
    step(1, BQ, 6'd0, 0, 1, E_F1,   "beq1_fetch");
    step(1, BQ, 6'd0, 0, 1, E_DEC,  "beq1_decode");
    step(1, BQ, 6'd0, 1, 1, E_BR1,  "beq_taken");
    step(1, BQ, 6'd0, 0, 1, E_F1,   "beq0_fetch");
    step(1, BQ, 6'd0, 0, 1, E_DEC,  "beq0_decode");
    step(1, BQ, 6'd0, 0, 1, E_BR0,  "beq_not_taken");
    // R-type variants
    step(1, RT, 6'b101010, 0, 1, E_F1,    "slt_fetch");
    step(1, RT, 6'b101010, 0, 1, E_DEC,   "slt_decode");
    step(1, RT, 6'b101010, 0, 1, E_EXSLT, "slt_execute");
    step(1, RT, 6'b101010, 0, 1, E_AWB,   "slt_aluwb");
    step(1, RT, 6'b100100, 0, 1, E_F1,    "and_fetch");
    step(1, RT, 6'b100100, 0, 1, E_DEC,   "and_decode");
    step(1, RT, 6'b100100, 0, 1, E_EXAND, "and_execute");
    step(1, RT, 6'b100100, 0, 1, E_AWB,   "and_aluwb");
    step(1, RT, 6'b100101, 0, 1, E_F1,    "or_fetch");
    step(1, RT, 6'b100101, 0, 1, E_DEC,   "or_decode");
    step(1, RT, 6'b100101, 0, 1, E_EXOR,  "or_execute");
    step(1, RT, 6'b100101, 0, 1, E_AWB,   "or_aluwb");
    step(1, RT, 6'b100010, 0, 1, E_F1,    "sub_fetch");
    step(1, RT, 6'b100010, 0, 1, E_DEC,   "sub_decode");
    step(1, RT, 6'b100010, 0, 1, E_EXSUB, "sub_execute");
    step(1, RT, 6'b100010, 0, 1, E_AWB,   "sub_aluwb");
    // bad funct: illegal, no ALUWB
    step(1, RT, 6'b111111, 0, 1, E_F1,    "badfn_fetch");
    step(1, RT, 6'b111111, 0, 1, E_DEC,   "badfn_decode");
    step(1, RT, 6'b111111, 0, 1, E_EXBAD, "badfn_execute");
    step(1, JP, 6'b111111, 0, 1, E_F1,    "badfn_back_to_fetch");
    // jump
    step(1, JP, 6'd0, 0, 1, E_DEC,  "j_decode");
    step(1, JP, 6'd0, 0, 1, E_JMP,  "j_jump");
    // addi
    step(1, AI, 6'd0, 0, 1, E_F1,   "addi_fetch");
`ifdef MC_CTRL_ADDI_EN
    step(1, AI, 6'd0, 0, 1, E_DEC,  "addi_decode");
    step(1, AI, 6'd0, 0, 1, E_AIEX, "addi_ex");
    step(1, AI, 6'd0, 0, 1, E_AIWB, "addi_wb");
`else
    step(1, AI, 6'd0, 0, 1, E_DECILL, "addi_illegal");
`endif
    // unknown opcode
    step(1, XX, 6'd0, 0, 1, E_F1,     "badop_fetch");
    step(1, XX, 6'd0, 0, 1, E_DECILL, "badop_decode");
    step(1, LW, 6'd0, 0, 1, E_F1,     "badop_back_to_fetch");
    // reset in MEMRD abandons the lw
    step(1, LW, 6'd0, 0, 1, E_DEC,  "rst_lw_decode");
    step(1, LW, 6'd0, 0, 1, E_MADR, "rst_lw_memadr");
    step(0, LW, 6'd0, 1, 1, E_RST,  "rst_mid_memrd");
    step(1, LW, 6'd0, 0, 1, E_F1,   "rst_refetch");
    step(1, LW, 6'd0, 0, 1, E_DEC,  "rst_refetch_decode");
    @(negedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
